// File: rtl/clk_slot_arbiter_if.sv
// Shared byte-channel bus between requesters and the slot arbiter.
// Word i of data_in sits at bits [32*i+31:32*i] of the packed array.
interface clk_slot_arbiter_if #(
   parameter int NREQ = 4
);
   logic                      en;
   logic [NREQ-1:0]           req;
   logic [NREQ-1:0][31:0]     data_in;
   logic [NREQ-1:0]           ack;
   logic [NREQ-1:0]           grant;
   logic [7:0]                byte_out;
   logic                      byte_valid;

   modport master (output en, req, data_in, input ack, grant, byte_out, byte_valid);
   modport slave  (input en, req, data_in, output ack, grant, byte_out, byte_valid);
endinterface

// File: rtl/clk_slot_arbiter.sv
// Round-robin slot arbiter: one 32-bit word per 16-cycle slot, sent MSB byte first,
// with registered 4f/2f/f phase strobes on clk16f.
module clk_slot_arbiter #(
   parameter int         NREQ      = 4,
   parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
   input  logic                clk16f,
   input  logic                reset,
   clk_slot_arbiter_if.slave   bus,
   output logic                stb4f,
   output logic                stb2f,
   output logic                stbf
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [3:0]    phase;
   logic [3:0]    phase_nxt;
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   logic [23:0]   rest;
   logic [NREQ-1:0] rot;
   logic [PW-1:0] off;
   logic [PW:0]   sum;
   logic [PW-1:0] win;
   logic          boundary;

   assign phase_nxt = phase + 4'd1;
   assign boundary  = (phase == 4'd15);

   // Rotate requests so the pointer sits at bit 0; the lowest set bit is the winner.
   always_comb begin
      rot = NREQ'({bus.req, bus.req} >> ptr);
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (rot[i]) off = PW'(i);
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      win     = sum[PW-1:0];
      ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
   end

   always_ff @(posedge clk16f) begin
      if (reset) begin
         phase          <= 4'd15;
         ptr            <= '0;
         rest           <= '0;
         bus.grant      <= '0;
         bus.ack        <= '0;
         bus.byte_valid <= 1'b0;
         bus.byte_out   <= IDLE_BYTE;
         stb4f          <= 1'b0;
         stb2f          <= 1'b0;
         stbf           <= 1'b0;
      end else begin
         phase   <= phase_nxt;
         stb4f   <= (phase_nxt[1:0] == 2'd0);
         stb2f   <= (phase_nxt[2:0] == 3'd0);
         stbf    <= (phase_nxt == 4'd0);
         bus.ack <= '0;
         if (boundary) begin
            if (bus.en && (|bus.req)) begin
               bus.grant      <= NREQ'(1) << win;
               bus.ack        <= NREQ'(1) << win;
               bus.byte_valid <= 1'b1;
               bus.byte_out   <= bus.data_in[win][31:24];
               rest           <= bus.data_in[win][23:0];
               ptr            <= ptr_nxt;
            end else begin
               bus.grant      <= '0;
               bus.byte_valid <= 1'b0;
               bus.byte_out   <= IDLE_BYTE;
            end
         end else if (bus.byte_valid && (phase_nxt[1:0] == 2'd0)) begin
            // Remaining bytes come from the word captured at the boundary, not data_in.
            bus.byte_out <= rest[23:16];
            rest         <= {rest[15:0], 8'h00};
         end
      end
   end
endmodule

// File: tb/tb_clk_slot_arbiter.sv
// Directed bench for clk_slot_arbiter: strobes, single grant, round-robin,
// mid-slot req drop, en gating and reset abort.
module tb_clk_slot_arbiter;
   logic clk16f = 1'b0;
   logic reset;
   logic stb4f, stb2f, stbf;
   int   checks   = 0;
   int   failures = 0;

   clk_slot_arbiter_if #(.NREQ(4)) bus ();

   clk_slot_arbiter #(.NREQ(4), .IDLE_BYTE(8'hBC)) dut (
      .clk16f (clk16f),
      .reset  (reset),
      .bus    (bus),
      .stb4f  (stb4f),
      .stb2f  (stb2f),
      .stbf   (stbf)
   );

   always #5 clk16f = ~clk16f;

   // One clock: outputs are sampled on the following falling edge.
   task automatic cyc();
      @(posedge clk16f);
      @(negedge clk16f);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rr_word(input int k);
      return 32'hA0B0C0D0 + 32'h01010101 * k;
   endfunction

   initial begin
      logic [31:0] w;
      logic [7:0]  b;
      int          winner;

      reset = 1'b1;
      bus.en = 1'b0;
      bus.req = '0;
      bus.data_in = '0;
      repeat (3) cyc();

      // Reset state
      chk("rst_grant", 32'(bus.grant), 32'h0);
      chk("rst_ack", 32'(bus.ack), 32'h0);
      chk("rst_bv", 32'(bus.byte_valid), 32'h0);
      chk("rst_byte", 32'(bus.byte_out), 32'hBC);
      chk("rst_stb", {29'h0, stbf, stb2f, stb4f}, 32'h0);

      // Test 1: strobes over an idle slot
      reset = 1'b0;
      bus.en = 1'b1;
      for (int c = 0; c < 16; c++) begin
         cyc();
         chk("t1_stb4f", 32'(stb4f), 32'((c % 4) == 0));
         chk("t1_stb2f", 32'(stb2f), 32'((c % 8) == 0));
         chk("t1_stbf", 32'(stbf), 32'(c == 0));
         chk("t1_idle_bv", 32'(bus.byte_valid), 32'h0);
         chk("t1_idle_byte", 32'(bus.byte_out), 32'hBC);
         if (c == 15) begin
            bus.req = 4'b0001;
            bus.data_in[0] = 32'hDEADBEEF;
         end
      end

      // Test 2: single granted slot, ptr moves 0 -> 1
      w = 32'hDEADBEEF;
      for (int c = 0; c < 16; c++) begin
         cyc();
         b = w[31 - 8*(c/4) -: 8];
         chk("t2_grant", 32'(bus.grant), 32'h1);
         chk("t2_ack", 32'(bus.ack), (c == 0) ? 32'h1 : 32'h0);
         chk("t2_bv", 32'(bus.byte_valid), 32'h1);
         chk("t2_byte", 32'(bus.byte_out), 32'(b));
         if (c == 15) begin
            bus.req = 4'b1111;
            for (int k = 0; k < 4; k++) bus.data_in[k] = rr_word(k);
         end
      end

      // Test 3: all requesting, pointer starts at 1
      for (int s = 0; s < 8; s++) begin
         winner = (1 + s) % 4;
         w = rr_word(winner);
         for (int c = 0; c < 16; c++) begin
            cyc();
            if (c == 0) begin
               chk("t3_grant", 32'(bus.grant), 32'(1) << winner);
               chk("t3_ack", 32'(bus.ack), 32'(1) << winner);
               chk("t3_byte0", 32'(bus.byte_out), 32'(w[31:24]));
            end
            if (c == 13) chk("t3_byte3", 32'(bus.byte_out), 32'(w[7:0]));
            if (c == 15) begin
               chk("t3_hold", 32'(bus.grant), 32'(1) << winner);
               chk("t3_bv", 32'(bus.byte_valid), 32'h1);
            end
            if (s == 7 && c == 15) begin
               bus.req = 4'b0100;
               bus.data_in[2] = 32'hCAFEF00D;
            end
         end
      end

      // Test 4: req[2] dropped and data changed mid-slot
      w = 32'hCAFEF00D;
      for (int c = 0; c < 16; c++) begin
         cyc();
         b = w[31 - 8*(c/4) -: 8];
         chk("t4_grant", 32'(bus.grant), 32'h4);
         chk("t4_byte", 32'(bus.byte_out), 32'(b));
         if (c == 5) begin
            bus.req = 4'b0000;
            bus.data_in[2] = 32'h12345678;
         end
      end
      for (int c = 0; c < 16; c++) begin
         cyc();
         chk("t4_idle_grant", 32'(bus.grant), 32'h0);
         chk("t4_idle_byte", 32'(bus.byte_out), 32'hBC);
         chk("t4_idle_ack", 32'(bus.ack), 32'h0);
         if (c == 15) begin
            bus.en = 1'b0;
            bus.req = 4'b0011;
            bus.data_in[0] = 32'h01020304;
            bus.data_in[1] = 32'h05060708;
         end
      end

      // Test 5: en=0 blocks a slot, then ptr=3 scans 3,0 -> 0 wins
      for (int c = 0; c < 16; c++) begin
         cyc();
         chk("t5_off_grant", 32'(bus.grant), 32'h0);
         chk("t5_off_bv", 32'(bus.byte_valid), 32'h0);
         if (c == 15) bus.en = 1'b1;
      end
      cyc();
      chk("t5_grant", 32'(bus.grant), 32'h1);
      chk("t5_ack", 32'(bus.ack), 32'h1);
      chk("t5_byte", 32'(bus.byte_out), 32'h01);
      repeat (15) cyc();

      // Test 6: requester 1 wins, reset at phase 6 aborts the slot
      for (int c = 0; c < 7; c++) begin
         cyc();
         if (c == 0) chk("t6_grant", 32'(bus.grant), 32'h2);
         if (c == 4) chk("t6_byte1", 32'(bus.byte_out), 32'h06);
      end
      reset = 1'b1;
      cyc();
      chk("t6_rst_bv", 32'(bus.byte_valid), 32'h0);
      chk("t6_rst_grant", 32'(bus.grant), 32'h0);
      chk("t6_rst_byte", 32'(bus.byte_out), 32'hBC);
      chk("t6_rst_stb", {29'h0, stbf, stb2f, stb4f}, 32'h0);
      cyc();
      chk("t6_rst_hold", 32'(bus.byte_out), 32'hBC);
      // With ptr back at 0, req 0110 picks requester 1 (a stale ptr of 2 would pick 2)
      reset = 1'b0;
      bus.req = 4'b0110;
      cyc();
      chk("t6_new_stbf", 32'(stbf), 32'h1);
      chk("t6_new_grant", 32'(bus.grant), 32'h2);
      chk("t6_new_byte", 32'(bus.byte_out), 32'h05);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
